// File: rtl/line_window_reader.sv
// line_window_reader: four rotating line buffers that present
// three vertically aligned rows as one column per accepted cycle.
module line_window_reader #(
    parameter int IMG_WIDTH = 512,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              wr_full_o,
    output logic [2:0]        lines_avail_o,
    input  logic              rd_ready_i,
    output logic              col_valid_o,
    output logic [DATA_W-1:0] top_o,
    output logic [DATA_W-1:0] mid_o,
    output logic [DATA_W-1:0] bot_o,
    output logic              line_end_o
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [DATA_W-1:0] mem [0:3][0:IMG_WIDTH-1];

    logic [1:0]    wr_buf;
    logic [CW-1:0] wr_col;
    logic [1:0]    rd_base;
    logic [CW-1:0] rd_col;
    logic [3:0]    full;
    logic [2:0]    fill_cnt;
    logic [2:0]    fill_nxt;
    logic [1:0]    state;

    logic wr_en;
    logic row_done;
    logic rel;
    logic slot_free;

    // The full flag of the target buffer also blocks the writer, so a
    // buffer still being read can never be overwritten.
    assign wr_en     = we_i & ~wr_full_o & ~full[wr_buf];
    assign row_done  = wr_en & (wr_col == LAST_COL);
    assign rel       = (state == RELEASE);
    assign slot_free = ~col_valid_o | rd_ready_i;

    assign lines_avail_o = fill_cnt;

    // Row count after this edge: completion and release cancel out.
    always_comb begin
        fill_nxt = fill_cnt;
        if (row_done && !rel) begin
            fill_nxt = fill_cnt + 3'd1;
        end else if (rel && !row_done) begin
            fill_nxt = fill_cnt - 3'd1;
        end
    end

    // Pixel storage; no reset needed since full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_buf][wr_col] <= data_i;
        end
    end

    // Write pointer: column within the row, then rotate to next buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_buf <= 2'd0;
            wr_col <= '0;
        end else if (wr_en) begin
            if (wr_col == LAST_COL) begin
                wr_col <= '0;
                wr_buf <= wr_buf + 2'd1;
            end else begin
                wr_col <= wr_col + CW'(1);
            end
        end
    end

    // Buffer occupancy: set on row completion, cleared on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 4'd0;
            fill_cnt  <= 3'd0;
            wr_full_o <= 1'b0;
        end else begin
            if (row_done) begin
                full[wr_buf] <= 1'b1;
            end
            if (rel) begin
                full[rd_base] <= 1'b0;
            end
            fill_cnt  <= fill_nxt;
            wr_full_o <= (fill_nxt == 3'd4);
        end
    end

    // Read FSM: stream three rows in lockstep, then retire the oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_base     <= 2'd0;
            rd_col      <= '0;
            col_valid_o <= 1'b0;
            line_end_o  <= 1'b0;
            top_o       <= '0;
            mid_o       <= '0;
            bot_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (col_valid_o && rd_ready_i) begin
                        col_valid_o <= 1'b0;
                    end
                    if (fill_cnt >= 3'd3) begin
                        state  <= READ;
                        rd_col <= '0;
                    end
                end
                READ: begin
                    if (slot_free) begin
                        top_o       <= mem[rd_base][rd_col];
                        mid_o       <= mem[rd_base + 2'd1][rd_col];
                        bot_o       <= mem[rd_base + 2'd2][rd_col];
                        col_valid_o <= 1'b1;
                        line_end_o  <= (rd_col == LAST_COL);
                        if (rd_col == LAST_COL) begin
                            rd_col <= '0;
                            state  <= RELEASE;
                        end else begin
                            rd_col <= rd_col + CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (col_valid_o && rd_ready_i) begin
                        col_valid_o <= 1'b0;
                    end
                    rd_base <= rd_base + 2'd1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_reader.sv
// tb_line_window_reader: directed stimulus with a column scoreboard
// checked at every accepted handshake.
module tb_line_window_reader;

    localparam int W  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] t;
        logic [DW-1:0] m;
        logic [DW-1:0] b;
        logic          le;
    } col_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          rd_ready_i = 1'b0;
    logic          wr_full_o;
    logic [2:0]    lines_avail_o;
    logic          col_valid_o;
    logic [DW-1:0] top_o;
    logic [DW-1:0] mid_o;
    logic [DW-1:0] bot_o;
    logic          line_end_o;

    col_t exp_q[$];
    col_t mon_got;
    col_t mon_exp;
    int   tests = 0;
    int   fails = 0;

    line_window_reader #(
        .IMG_WIDTH(W),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we_i(we_i),
        .data_i(data_i),
        .wr_full_o(wr_full_o),
        .lines_avail_o(lines_avail_o),
        .rd_ready_i(rd_ready_i),
        .col_valid_o(col_valid_o),
        .top_o(top_o),
        .mid_o(mid_o),
        .bot_o(bot_o),
        .line_end_o(line_end_o)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_px(input int v);
        int n;
        n = 0;
        while (wr_full_o && n < 200) begin
            tick();
            n++;
        end
        check("wr_stall_timeout", 32'(n < 200), 32'd1);
        we_i   = 1'b1;
        data_i = DW'(v);
        tick();
        we_i   = 1'b0;
    endtask

    task automatic wr_rows(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wr_px(first + i);
        end
    endtask

    task automatic push_pass(input int base);
        col_t c;
        for (int i = 0; i < W; i++) begin
            c.t  = DW'(base + i);
            c.m  = DW'(base + W + i);
            c.b  = DW'(base + 2 * W + i);
            c.le = (i == W - 1);
            exp_q.push_back(c);
        end
    endtask

    task automatic wait_top(input int v);
        int n;
        n = 0;
        while (!(col_valid_o && top_o == DW'(v)) && n < 50) begin
            tick();
            n++;
        end
        check("wait_col", 32'(n < 50), 32'd1);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        we_i       = 1'b0;
        rd_ready_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: compare each column at the cycle it is accepted.
    always @(negedge clk) begin
        if (!rst && col_valid_o && rd_ready_i) begin
            mon_got = {top_o, mid_o, bot_o, line_end_o};
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_col: got %0h expected none",
                       mon_got);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                tests++;
                assert (mon_got === mon_exp) else begin
                    fails++;
                    $error("FAIL col: got %0h expected %0h",
                           mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        // 1. reset
        do_reset();
        check("rst_valid", 32'(col_valid_o), 32'd0);
        check("rst_top", 32'(top_o), 32'd0);
        check("rst_mid", 32'(mid_o), 32'd0);
        check("rst_bot", 32'(bot_o), 32'd0);
        check("rst_le", 32'(line_end_o), 32'd0);
        check("rst_full", 32'(wr_full_o), 32'd0);
        check("rst_avail", 32'(lines_avail_o), 32'd0);

        // 2. basic window and latency
        rd_ready_i = 1'b1;
        push_pass(0);
        wr_rows(0, 12);
        check("s2_avail3", 32'(lines_avail_o), 32'd3);
        check("s2_lat0", 32'(col_valid_o), 32'd0);
        tick();
        check("s2_lat1", 32'(col_valid_o), 32'd0);
        tick();
        check("s2_lat2", 32'(col_valid_o), 32'd1);
        check("s2_first_top", 32'(top_o), 32'd0);
        drain(20);
        repeat (3) tick();
        check("s2_avail2", 32'(lines_avail_o), 32'd2);
        check("s2_idle", 32'(col_valid_o), 32'd0);

        // 3. backpressure
        do_reset();
        rd_ready_i = 1'b1;
        push_pass(0);
        wr_rows(0, 12);
        wait_top(1);
        rd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_hold_v", 32'(col_valid_o), 32'd1);
            check("s3_hold", {8'd0, top_o, mid_o, bot_o},
                  {8'd0, 8'd1, 8'd5, 8'd9});
        end
        rd_ready_i = 1'b1;
        tick();
        check("s3_resume", {8'd0, top_o, mid_o, bot_o},
              {8'd0, 8'd2, 8'd6, 8'd10});
        drain(20);

        // 4. full and dropped write
        do_reset();
        wr_rows(0, 16);
        check("s4_full", 32'(wr_full_o), 32'd1);
        check("s4_avail4", 32'(lines_avail_o), 32'd4);
        we_i   = 1'b1;
        data_i = 8'd99;
        tick();
        we_i = 1'b0;
        check("s4_drop_full", 32'(wr_full_o), 32'd1);
        check("s4_drop_avail", 32'(lines_avail_o), 32'd4);
        check("s4_held_top", 32'(top_o), 32'd0);
        push_pass(0);
        push_pass(4);
        push_pass(8);
        rd_ready_i = 1'b1;
        begin
            int n;
            n = 0;
            while (wr_full_o && n < 40) begin
                tick();
                n++;
            end
            check("s4_full_clear", 32'(wr_full_o), 32'd0);
        end
        check("s4_avail3", 32'(lines_avail_o), 32'd3);
        wr_rows(16, 4);
        drain(60);
        repeat (3) tick();
        check("s4_end_avail", 32'(lines_avail_o), 32'd2);
        check("s4_end_idle", 32'(col_valid_o), 32'd0);

        // 5. sliding rows with writer flow control
        do_reset();
        rd_ready_i = 1'b1;
        push_pass(0);
        push_pass(4);
        push_pass(8);
        wr_rows(0, 20);
        drain(60);
        repeat (3) tick();
        check("s5_avail2", 32'(lines_avail_o), 32'd2);

        // 6. reset during READ
        do_reset();
        rd_ready_i = 1'b1;
        push_pass(0);
        wr_rows(0, 12);
        wait_top(1);
        rst = 1'b1;
        tick();
        check("s6_valid", 32'(col_valid_o), 32'd0);
        check("s6_data", {8'd0, top_o, mid_o, bot_o}, 32'd0);
        check("s6_le", 32'(line_end_o), 32'd0);
        check("s6_avail", 32'(lines_avail_o), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        push_pass(20);
        wr_rows(20, 12);
        wait_top(20);
        check("s6_first", {8'd0, top_o, mid_o, bot_o},
              {8'd0, 8'd20, 8'd24, 8'd28});
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_window_reader.md
Name: line_window_reader

Overview:
- Read side of the Sobel line-buffering path.
- Holds four rotating line buffers. Rows are written pixel-by-pixel using the same we_i/data_i write convention as the single line buffer.
- Once three complete rows are resident, it reads them back in lockstep and emits one vertically aligned 3-pixel column (top/mid/bot) per accepted cycle, with a valid/ready handshake.
- Feeds the 3x3 window assembler and Sobel kernel downstream.

Parameters:
- IMG_WIDTH, 512, pixels per row; a power of two is not required.
- DATA_W, 8, bits per pixel.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- we_i, input, 1, pixel write strobe.
- data_i, input, DATA_W, pixel being written.
- wr_full_o, output, 1, all four buffers full; writes are ignored while high.
- lines_avail_o, output, 3, number of complete rows resident (0..4).
- rd_ready_i, input, 1, downstream accepts the current column.
- col_valid_o, output, 1, top_o/mid_o/bot_o hold a valid column.
- top_o, output, DATA_W, pixel from the oldest resident row.
- mid_o, output, DATA_W, pixel from the next row.
- bot_o, output, DATA_W, pixel from the newest row of the three.
- line_end_o, output, 1, qualifies the last column of a row (valid with col_valid_o).

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_buf, wr_col, rd_base, rd_col, fill_cnt and all full flags go to 0; state goes to IDLE.
  - All outputs go to 0.
  - Reset mid-operation discards all stored rows and any pending column.
- Write side:
  - Address is wr_buf (0..3) and wr_col (0..IMG_WIDTH-1).
  - On we_i=1 and wr_full_o=0: mem[wr_buf][wr_col] <= data_i, then wr_col increments.
  - At wr_col=IMG_WIDTH-1, wr_col wraps to 0, full[wr_buf] is set, wr_buf <= (wr_buf+1) mod 4 and fill_cnt increments.
  - we_i=1 while wr_full_o=1 is dropped with no state change.
- Fill count:
  - wr_full_o = (fill_cnt==4); lines_avail_o = fill_cnt. Both are registered.
  - A row completion and a release in the same cycle leave fill_cnt unchanged and apply both flag updates.
- Read FSM:
  - IDLE: if fill_cnt>=3, go to READ on the next edge with rd_col=0.
  - READ: a slot is free when col_valid_o=0 or rd_ready_i=1. On a free-slot edge:
    - top_o <= mem[rd_base][rd_col], mid_o <= mem[rd_base+1][rd_col], bot_o <= mem[rd_base+2][rd_col], with buffer indices mod 4.
    - col_valid_o <= 1; line_end_o <= (rd_col==IMG_WIDTH-1); rd_col increments.
    - After issuing the last column, go to RELEASE.
    - If the slot is not free, all outputs hold stable.
  - RELEASE (one cycle): clear full[rd_base], decrement fill_cnt, rd_base <= rd_base+1 mod 4, go to IDLE. The pending last column remains presented until accepted.
  - In IDLE/RELEASE, col_valid_o drops to 0 on the edge where rd_ready_i=1 and it was 1.
- Latency: the first column is valid two edges after the edge that captures the final pixel of the third row. Each row boundary costs two bubble cycles (RELEASE and IDLE).
- Rows advance by one per pass, i.e. a sliding window: rows 0-2, then 1-3, then 2-4. The writer can never overwrite a buffer still being read, because that buffer's full flag blocks the rotation.
- The read port samples memory registered; reading a column the writer targets in the same cycle is impossible by construction.

Test Plan:
All scenarios use IMG_WIDTH=4.
1. Reset: assert rst for 2 cycles -> col_valid_o=0, top/mid/bot=0, line_end_o=0, wr_full_o=0, lines_avail_o=0.
2. Basic window: write data 0..11 on consecutive cycles with rd_ready_i=1 -> lines_avail_o=3.
   - Two edges later, columns (0,4,8), (1,5,9), (2,6,10), (3,7,11) appear on consecutive cycles.
   - line_end_o=1 only with (3,7,11).
   - lines_avail_o then drops to 2.
3. Backpressure: repeat scenario 2, dropping rd_ready_i low while (1,5,9) is valid for 3 cycles -> outputs hold (1,5,9); then (2,6,10) follows on resume.
4. Full and drop: write 0..15 with rd_ready_i=0 -> wr_full_o=1, lines_avail_o=4.
   - A 17th write of 99 is ignored.
   - Set rd_ready_i=1 -> rows 0-2 drain, wr_full_o clears after RELEASE, and a subsequent write lands at column 0 of buffer 0.
5. Sliding rows: write 0..19 with rd_ready_i=1 -> the second pass emits (4,8,12), (5,9,13), (6,10,14), (7,11,15) with line_end_o on the last.
   - The third pass emits (8,12,16)..(11,15,19).
6. Reset mid-READ: assert rst after (1,5,9) is emitted -> all outputs are 0 next cycle and lines_avail_o=0.
   - Writing 12 new pixels 20..31 yields (20,24,28) first.
